// File: rtl/audio_gain_stage.sv
// Audio gain stage: one sample per clk_sample_i rising edge, Q2.6 gain, saturating, 3-cycle edge-to-load latency.
// Optional macro AUDIO_GAIN_RAMP_EN: cur_gain slews by one LSB per accepted sample toward gain_i.
module audio_gain_stage #(
  parameter int DATA_W = 24,
  parameter int GAIN_W = 8
) (
  input  logic              clk_12mhz_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clk_sample_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [GAIN_W-1:0] gain_i,
  input  logic              mute_i,
  output logic [DATA_W-1:0] data_o,
  output logic              load_o,
  output logic              sat_o,
  output logic              overrun_o
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int SHR_W  = PROD_W - 6;
  localparam int TOP_W  = SHR_W - DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    SAT  = 2'd2,
    LOAD = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     clk_sample_q;
  logic                     edge_s, accept_s;
  logic [DATA_W-1:0]        sample_q, sample_d;
  logic [GAIN_W-1:0]        cur_gain_q, cur_gain_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [PROD_W-1:0] sample_ext_s, gain_ext_s;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     load_q, load_d;
  logic                     sat_q, sat_d;
  logic                     overrun_q, overrun_d;
  logic [DATA_W:0]          sat_res_s;

  // Returns {clipped, value}: product >>> 6 clamped to the DATA_W two's complement range.
  function automatic logic [DATA_W:0] saturate(input logic signed [PROD_W-1:0] p);
    logic [SHR_W-1:0] s;
    logic [TOP_W-1:0] top;
    s   = p[PROD_W-1:6];
    top = s[SHR_W-1:DATA_W-1];
    if ((&top) || (~|top)) begin
      saturate = {1'b0, s[DATA_W-1:0]};
    end else if (s[SHR_W-1]) begin
      saturate = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      saturate = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  assign edge_s       = clk_sample_i & ~clk_sample_q;
  assign accept_s     = edge_s & en_i & (state_q == IDLE);
  assign sample_ext_s = {{(GAIN_W+1){sample_q[DATA_W-1]}}, sample_q};
  assign gain_ext_s   = {{DATA_W{1'b0}}, 1'b0, cur_gain_q};
  assign sat_res_s    = saturate(prod_q);

  // State register.
  always_ff @(posedge clk_12mhz_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each active state lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      MULT:    state_d = SAT;
      SAT:     state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state; edges outside IDLE are dropped and flagged.
  always_comb begin
    sample_d   = sample_q;
    cur_gain_d = cur_gain_q;
    prod_d     = prod_q;
    data_d     = data_q;
    load_d     = 1'b0;
    sat_d      = sat_q;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sample_d = sample_i;
`ifdef AUDIO_GAIN_RAMP_EN
          if (gain_i > cur_gain_q) begin
            cur_gain_d = cur_gain_q + GAIN_W'(1);
          end else if (gain_i < cur_gain_q) begin
            cur_gain_d = cur_gain_q - GAIN_W'(1);
          end else begin
            cur_gain_d = cur_gain_q;
          end
`else
          cur_gain_d = gain_i;
`endif
        end else begin
          sample_d = sample_q;
        end
      end
      MULT: begin
        overrun_d = overrun_q | edge_s;
        if (mute_i) begin
          prod_d = {PROD_W{1'b0}};
        end else begin
          prod_d = sample_ext_s * gain_ext_s;
        end
      end
      SAT: begin
        overrun_d = overrun_q | edge_s;
        data_d    = sat_res_s[DATA_W-1:0];
        load_d    = 1'b1;
        sat_d     = sat_q | sat_res_s[DATA_W];
      end
      LOAD: begin
        overrun_d = overrun_q | edge_s;
      end
      default: begin
        overrun_d = overrun_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_12mhz_i) begin
    if (rst_i) begin
      clk_sample_q <= 1'b0;
      sample_q     <= {DATA_W{1'b0}};
      cur_gain_q   <= GAIN_W'(64);
      prod_q       <= {PROD_W{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      load_q       <= 1'b0;
      sat_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      clk_sample_q <= clk_sample_i;
      sample_q     <= sample_d;
      cur_gain_q   <= cur_gain_d;
      prod_q       <= prod_d;
      data_q       <= data_d;
      load_q       <= load_d;
      sat_q        <= sat_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign load_o    = load_q;
  assign sat_o     = sat_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_audio_gain_stage.sv
// Self-checking bench for audio_gain_stage: vector table plus scoreboard, and hand sequences for
// overrun, enable, mid-sample reset and gain ramp (expectations follow AUDIO_GAIN_RAMP_EN).
module tb_audio_gain_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic        clk_sample_i = 1'b0;
  logic [23:0] sample_i = 24'h0;
  logic [7:0]  gain_i = 8'd64;
  logic        mute_i = 1'b0;
  logic [23:0] data_o;
  logic        load_o, sat_o, overrun_o;

  audio_gain_stage #(.DATA_W(24), .GAIN_W(8)) dut (
    .clk_12mhz_i (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .clk_sample_i(clk_sample_i),
    .sample_i    (sample_i),
    .gain_i      (gain_i),
    .mute_i      (mute_i),
    .data_o      (data_o),
    .load_o      (load_o),
    .sat_o       (sat_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] sample;
    logic [7:0]  gain;
    logic        mute;
    logic [23:0] exp_data;
    logic        clip;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic        sat;
    int          cyc;
  } sb_t;

  vec_t vecs[10];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   load_cnt = 0;
  logic exp_sticky = 1'b0;
  logic [7:0] model_gain = 8'd64;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && load_o) begin
        load_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_load: got load_o=1 data_o=%0h expected no load", data_o);
        end else begin
          e = sb.pop_front();
          chk("load_data", {8'h0, data_o}, {8'h0, e.data});
          chk("load_sat", {31'h0, sat_o}, {31'h0, e.sat});
          chk("load_latency", cyc, e.cyc + 3);
        end
      end
    end
  endtask

  task automatic push_exp(input logic [23:0] d, input logic clip, input logic [7:0] g);
    sb_t e;
    exp_sticky = exp_sticky | clip;
    e.data = d;
    e.sat  = exp_sticky;
    e.cyc  = cyc;
    sb.push_back(e);
`ifdef AUDIO_GAIN_RAMP_EN
    if (g > model_gain) model_gain = model_gain + 8'd1;
    else if (g < model_gain) model_gain = model_gain - 8'd1;
`else
    model_gain = g;
`endif
  endtask

  task automatic send(input logic [23:0] s, input logic [7:0] g, input logic m,
                      input logic [23:0] exp_d, input logic clip);
    @(posedge clk); #1;
    sample_i = s; gain_i = g; mute_i = m; clk_sample_i = 1'b1;
    push_exp(exp_d, clip, g);
    @(posedge clk); #1;
    clk_sample_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 mute_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1; clk_sample_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_sticky = 1'b0;
    model_gain = 8'd64;
  endtask

  initial begin
    int lc;
    sb_t e;
    vecs[0] = '{24'h123456, 8'd64,  1'b0, 24'h123456, 1'b0};
    vecs[1] = '{24'h7FFFFF, 8'd0,   1'b0, 24'h000000, 1'b0};
    vecs[2] = '{24'hFFFFFE, 8'd32,  1'b0, 24'hFFFFFF, 1'b0};
    vecs[3] = '{24'h7FFFFF, 8'd255, 1'b1, 24'h000000, 1'b0};
    vecs[4] = '{24'h800000, 8'd64,  1'b0, 24'h800000, 1'b0};
    vecs[5] = '{24'h001000, 8'd128, 1'b0, 24'h002000, 1'b0};
    vecs[6] = '{24'h400000, 8'd255, 1'b0, 24'h7FFFFF, 1'b1};
    vecs[7] = '{24'hC00000, 8'd255, 1'b0, 24'h800000, 1'b1};
    vecs[8] = '{24'h100000, 8'd192, 1'b0, 24'h300000, 1'b0};
    vecs[9] = '{24'hF00000, 8'd100, 1'b0, 24'hE70000, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {8'h0, data_o}, 32'h0);
    chk("rst_load", {31'h0, load_o}, 32'h0);
    chk("rst_sat", {31'h0, sat_o}, 32'h0);
    chk("rst_overrun", {31'h0, overrun_o}, 32'h0);
    @(posedge clk); #1 rst_i = 1'b0;

    fork
      monitor();
    join_none

    for (int i = 0; i < 10; i++) begin
`ifdef AUDIO_GAIN_RAMP_EN
      while (model_gain != vecs[i].gain) send(24'h0, vecs[i].gain, 1'b0, 24'h0, 1'b0);
`endif
      send(vecs[i].sample, vecs[i].gain, vecs[i].mute, vecs[i].exp_data, vecs[i].clip);
    end

    // en_i low in IDLE: edge ignored, no overrun
    lc = load_cnt;
    @(posedge clk); #1 en_i = 1'b0; clk_sample_i = 1'b1;
    @(posedge clk); #1 clk_sample_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("en_off_loads", load_cnt, lc);
    chk("en_off_overrun", {31'h0, overrun_o}, 32'h0);

    // en_i dropped while a sample is in flight: it still completes
    @(posedge clk); #1 en_i = 1'b1; sample_i = 24'h000040; gain_i = 8'd100; clk_sample_i = 1'b1;
    push_exp(24'h000064, 1'b0, 8'd100);
    @(posedge clk); #1 en_i = 1'b0; clk_sample_i = 1'b0;
    repeat (6) @(posedge clk);
    #1 en_i = 1'b1;

    // Reset one cycle after the edge: sample aborted, outputs cleared
    lc = load_cnt;
    @(posedge clk); #1 sample_i = 24'h123456; clk_sample_i = 1'b1;
    @(posedge clk); #1 clk_sample_i = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    exp_sticky = 1'b0;
    model_gain = 8'd64;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midrst_loads", load_cnt, lc);
    chk("midrst_data", {8'h0, data_o}, 32'h0);
    chk("midrst_load", {31'h0, load_o}, 32'h0);
    chk("midrst_sat", {31'h0, sat_o}, 32'h0);
    chk("midrst_overrun", {31'h0, overrun_o}, 32'h0);

    // Second edge two cycles after the first: dropped, overrun flagged
    lc = load_cnt;
    @(posedge clk); #1 sample_i = 24'h000100; gain_i = 8'd64; clk_sample_i = 1'b1;
    push_exp(24'h000100, 1'b0, 8'd64);
    @(posedge clk); #1 clk_sample_i = 1'b0; sample_i = 24'h7FFFFF;
    @(posedge clk); #1 clk_sample_i = 1'b1;
    @(posedge clk); #1 clk_sample_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("overrun_loads", load_cnt, lc + 1);
    chk("overrun_flag", {31'h0, overrun_o}, 32'h1);
    chk("overrun_sat", {31'h0, sat_o}, 32'h0);

    // Gain change 64 -> 68 over four samples
    do_reset();
`ifdef AUDIO_GAIN_RAMP_EN
    send(24'h001000, 8'd68, 1'b0, 24'h001040, 1'b0);
    send(24'h001000, 8'd68, 1'b0, 24'h001080, 1'b0);
    send(24'h001000, 8'd68, 1'b0, 24'h0010C0, 1'b0);
    send(24'h001000, 8'd68, 1'b0, 24'h001100, 1'b0);
`else
    send(24'h001000, 8'd68, 1'b0, 24'h001100, 1'b0);
    send(24'h001000, 8'd68, 1'b0, 24'h001100, 1'b0);
    send(24'h001000, 8'd68, 1'b0, 24'h001100, 1'b0);
    send(24'h001000, 8'd68, 1'b0, 24'h001100, 1'b0);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_load: got no load_o expected data_o=%0h (edge cycle %0d)", e.data, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
